// File: rtl/fifo36_to_ll8_pkg.sv
// Shared definitions for the 36-bit FIFO to 8-bit LocalLink serializer:
// word field positions, framing state encoding and the occ decode.
package fifo36_to_ll8_pkg;

  localparam int unsigned SOF_BIT = 32;
  localparam int unsigned EOF_BIT = 33;
  localparam int unsigned OCC_LSB = 34;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_PKT   = 1'b1
  } state_e;

  // Number of valid bytes carried by an EOF word; occ of zero means a full word.
  function automatic logic [2:0] occ_to_nbytes(input logic [1:0] occ);
    logic [2:0] nbytes;
    case (occ)
      2'd0:    nbytes = 3'd4;
      2'd1:    nbytes = 3'd1;
      2'd2:    nbytes = 3'd2;
      2'd3:    nbytes = 3'd3;
      default: nbytes = 3'd4;
    endcase
    return nbytes;
  endfunction

endpackage

// File: rtl/fifo36_to_ll8.sv
// Serializes 36-bit FIFO words (data + SOF/EOF/occ) into 8-bit LocalLink bytes.
// A single holding register feeds the byte mux; a new word is accepted in the
// same cycle its predecessor's last byte leaves, so the stream has no bubbles.
module fifo36_to_ll8
  import fifo36_to_ll8_pkg::*;
#(
  parameter bit LE = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic [35:0] datain,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [7:0]  ll_data,
  output logic        ll_sof_n,
  output logic        ll_eof_n,
  output logic        ll_src_rdy_n,
  input  logic        ll_dst_rdy_n,
  output logic        framing_err
);

  logic [35:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic [1:0]  idx_q, idx_d;
  state_e      state_q, state_d;
  logic        ferr_q, ferr_d;

  logic        sof_s;
  logic        eof_s;
  logic [2:0]  nbytes_s;
  logic [2:0]  last_idx_s;
  logic        last_byte_s;
  logic [1:0]  lane_s;
  logic [7:0]  byte_s;
  logic        in_xfer_s;
  logic        out_xfer_s;

  // Decode the held word: framing flags, last-byte position and selected byte lane.
  always_comb begin
    sof_s      = word_q[SOF_BIT];
    eof_s      = word_q[EOF_BIT];
    nbytes_s   = occ_to_nbytes(word_q[OCC_LSB +: 2]);
    last_idx_s = 3'd3;
    if (eof_s) begin
      last_idx_s = nbytes_s - 3'd1;
    end else begin
      last_idx_s = 3'd3;
    end
    last_byte_s = (idx_q == last_idx_s[1:0]);
    // Big-endian order walks lanes 3..0, little-endian walks 0..3.
    if (LE) begin
      lane_s = idx_q;
    end else begin
      lane_s = 2'd3 - idx_q;
    end
    case (lane_s)
      2'd0:    byte_s = word_q[7:0];
      2'd1:    byte_s = word_q[15:8];
      2'd2:    byte_s = word_q[23:16];
      2'd3:    byte_s = word_q[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  // Handshakes: the register frees up when its last byte is taken this cycle.
  always_comb begin
    dst_rdy_o  = ~valid_q | (last_byte_s & ~ll_dst_rdy_n);
    in_xfer_s  = src_rdy_i & dst_rdy_o;
    out_xfer_s = valid_q & ~ll_dst_rdy_n;
  end

  // LocalLink outputs derive only from registered state, so they hold under backpressure.
  always_comb begin
    ll_src_rdy_n = ~valid_q;
    ll_data      = valid_q ? byte_s : 8'h00;
    ll_sof_n     = ~(valid_q & sof_s & (idx_q == 2'd0));
    ll_eof_n     = ~(valid_q & eof_s & last_byte_s);
    framing_err  = ferr_q;
  end

  // Next state: drain bytes, then accept a new word and track packet framing.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    state_d = state_q;
    ferr_d  = 1'b0;

    if (out_xfer_s) begin
      if (last_byte_s) begin
        valid_d = 1'b0;
        idx_d   = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end else begin
      idx_d = idx_q;
    end

    if (in_xfer_s) begin
      case (state_q)
        WAIT_SOF: begin
          if (datain[SOF_BIT]) begin
            word_d  = datain;
            valid_d = 1'b1;
            idx_d   = 2'd0;
            state_d = datain[EOF_BIT] ? WAIT_SOF : IN_PKT;
          end else begin
            // Orphan word outside a packet: swallow it and flag the error.
            ferr_d = 1'b1;
          end
        end
        IN_PKT: begin
          // A SOF here abandons the open packet; the new word still starts one.
          word_d  = datain;
          valid_d = 1'b1;
          idx_d   = 2'd0;
          ferr_d  = datain[SOF_BIT];
          state_d = datain[EOF_BIT] ? WAIT_SOF : IN_PKT;
        end
        default: begin
          state_d = WAIT_SOF;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers; reset and clear both drop any held word immediately.
  always_ff @(posedge clock) begin
    if (reset | clear) begin
      word_q  <= 36'h0;
      valid_q <= 1'b0;
      idx_q   <= 2'd0;
      state_q <= WAIT_SOF;
      ferr_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule

// File: tb/tb_fifo36_to_ll8.sv
// Bench for fifo36_to_ll8: two instances (LE=0 and LE=1) share the stimulus and
// are checked every cycle against a byte-queue model of the stream.
module tb_fifo36_to_ll8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [35:0] datain = 36'h0;
  logic        src_rdy_i = 1'b0;
  logic        ll_dst_rdy_n = 1'b0;
  logic        toggle = 1'b0;

  logic        dst_rdy0, dst_rdy1;
  logic [7:0]  ll_data0, ll_data1;
  logic        sof_n0, sof_n1, eof_n0, eof_n1, src_rdy_n0, src_rdy_n1, ferr0, ferr1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ferr_cnt = 0;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sof;
    logic       eof;
  } ent_t;

  ent_t q[$];
  logic model_in_pkt = 1'b0;
  logic exp_ferr = 1'b0;

  logic [7:0] log_d0[$];
  logic [7:0] log_d1[$];
  logic       log_sof[$];
  logic       log_eof[$];
  int         log_cyc[$];

  fifo36_to_ll8 #(.LE(1'b0)) dut0 (
    .clock(clock), .reset(reset), .clear(clear), .datain(datain), .src_rdy_i(src_rdy_i),
    .dst_rdy_o(dst_rdy0), .ll_data(ll_data0), .ll_sof_n(sof_n0), .ll_eof_n(eof_n0),
    .ll_src_rdy_n(src_rdy_n0), .ll_dst_rdy_n(ll_dst_rdy_n), .framing_err(ferr0)
  );

  fifo36_to_ll8 #(.LE(1'b1)) dut1 (
    .clock(clock), .reset(reset), .clear(clear), .datain(datain), .src_rdy_i(src_rdy_i),
    .dst_rdy_o(dst_rdy1), .ll_data(ll_data1), .ll_sof_n(sof_n1), .ll_eof_n(eof_n1),
    .ll_src_rdy_n(src_rdy_n1), .ll_dst_rdy_n(ll_dst_rdy_n), .framing_err(ferr1)
  );

  initial forever #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [35:0] mk(input logic [1:0] occ, input logic eof, input logic sof,
                                     input logic [31:0] d);
    return {occ, eof, sof, d};
  endfunction

  // Expand an accepted word into its expected bytes for both byte orders.
  task automatic model_push(input logic [35:0] w);
    int nb;
    ent_t e;
    nb = 4;
    if (w[33] && w[35:34] != 2'd0) nb = int'(w[35:34]);
    for (int i = 0; i < nb; i++) begin
      e.d0  = 8'(w[31:0] >> (8 * (3 - i)));
      e.d1  = 8'(w[31:0] >> (8 * i));
      e.sof = w[32] && (i == 0);
      e.eof = w[33] && (i == nb - 1);
      q.push_back(e);
    end
  endtask

  // Sink: always ready, or toggling every cycle when requested.
  initial forever begin
    @(posedge clock);
    #1;
    if (toggle) ll_dst_rdy_n = ~ll_dst_rdy_n;
    else ll_dst_rdy_n = 1'b0;
  end

  // Compare process: outputs are stable at the falling edge; check, then
  // advance the model by what the coming rising edge will do.
  initial forever begin
    logic exp_rdy;
    @(negedge clock);
    exp_rdy = (q.size() == 0) || (q.size() == 1 && !ll_dst_rdy_n);
    chk("dst_rdy0", dst_rdy0, exp_rdy);
    chk("dst_rdy1", dst_rdy1, exp_rdy);
    chk("ferr0", ferr0, exp_ferr);
    chk("ferr1", ferr1, exp_ferr);
    if (ferr0) ferr_cnt = ferr_cnt + 1;
    if (q.size() != 0) begin
      chk("src_rdy_n0", src_rdy_n0, 1'b0);
      chk("src_rdy_n1", src_rdy_n1, 1'b0);
      chk("data0", ll_data0, q[0].d0);
      chk("data1", ll_data1, q[0].d1);
      chk("sof_n0", sof_n0, !q[0].sof);
      chk("sof_n1", sof_n1, !q[0].sof);
      chk("eof_n0", eof_n0, !q[0].eof);
      chk("eof_n1", eof_n1, !q[0].eof);
    end else begin
      chk("idle_src_rdy_n0", src_rdy_n0, 1'b1);
      chk("idle_src_rdy_n1", src_rdy_n1, 1'b1);
    end
    exp_ferr = 1'b0;
    if (reset || clear) begin
      q.delete();
      model_in_pkt = 1'b0;
    end else begin
      if (q.size() != 0 && !ll_dst_rdy_n) begin
        log_d0.push_back(ll_data0);
        log_d1.push_back(ll_data1);
        log_sof.push_back(sof_n0);
        log_eof.push_back(eof_n0);
        log_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (src_rdy_i && dst_rdy0) begin
        if (!model_in_pkt && !datain[32]) begin
          exp_ferr = 1'b1;
        end else begin
          exp_ferr = model_in_pkt && datain[32];
          model_push(datain);
          model_in_pkt = !datain[33];
        end
      end
    end
  end

  task automatic send(input logic [35:0] w);
    int n;
    logic a;
    datain = w;
    src_rdy_i = 1'b1;
    n = 0;
    a = 1'b0;
    while (!a && n < 200) begin
      @(negedge clock);
      a = dst_rdy0;
      @(posedge clock);
      #1;
      n++;
    end
    if (!a) chk("send_timeout", 32'd0, 32'd1);
    src_rdy_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_pkt1(input int base);
    chk("pkt1_len", log_d0.size() - base, 12);
    for (int i = 0; i < 12; i++) chk("pkt1_byte", log_d0[base + i], i + 1);
    chk("pkt1_sof_first", log_sof[base], 1'b0);
    chk("pkt1_sof_second", log_sof[base + 1], 1'b1);
    chk("pkt1_eof_last", log_eof[base + 11], 1'b0);
    chk("pkt1_eof_prev", log_eof[base + 10], 1'b1);
  endtask

  initial begin
    int base;
    int n;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_src_rdy_n", src_rdy_n0, 1'b1);
    chk("rst_sof_n", sof_n0, 1'b1);
    chk("rst_eof_n", eof_n0, 1'b1);
    chk("rst_data", ll_data0, 8'h00);
    chk("rst_ferr", ferr0, 1'b0);
    chk("rst_dst_rdy", dst_rdy0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Three-word packet, full last word, sink always ready.
    base = log_d0.size();
    send(mk(2'd0, 1'b0, 1'b1, 32'h01020304));
    send(mk(2'd0, 1'b0, 1'b0, 32'h05060708));
    send(mk(2'd0, 1'b1, 1'b0, 32'h090A0B0C));
    drain();
    check_pkt1(base);
    chk("pkt1_rate", log_cyc[base + 11] - log_cyc[base], 11);
    chk("pkt1_le1_first", log_d1[base], 8'h04);

    // Same packet with a two-byte final word.
    base = log_d0.size();
    send(mk(2'd0, 1'b0, 1'b1, 32'h01020304));
    send(mk(2'd0, 1'b0, 1'b0, 32'h05060708));
    send(mk(2'd2, 1'b1, 1'b0, 32'h090A0B0C));
    drain();
    chk("pkt2_len", log_d0.size() - base, 10);
    chk("pkt2_byte9", log_d0[base + 8], 8'h09);
    chk("pkt2_last", log_d0[base + 9], 8'h0A);
    chk("pkt2_eof", log_eof[base + 9], 1'b0);
    chk("pkt2_le1_last", log_d1[base + 9], 8'h0B);

    // Single-word packet of one byte.
    base = log_d0.size();
    send(mk(2'd1, 1'b1, 1'b1, 32'hAABBCCDD));
    drain();
    chk("single_len", log_d0.size() - base, 1);
    chk("single_le0", log_d0[base], 8'hAA);
    chk("single_le1", log_d1[base], 8'hDD);
    chk("single_sof", log_sof[base], 1'b0);
    chk("single_eof", log_eof[base], 1'b0);

    // Toggling sink: same bytes, held while not ready.
    toggle = 1'b1;
    base = log_d0.size();
    send(mk(2'd0, 1'b0, 1'b1, 32'h01020304));
    send(mk(2'd0, 1'b0, 1'b0, 32'h05060708));
    send(mk(2'd0, 1'b1, 1'b0, 32'h090A0B0C));
    drain();
    check_pkt1(base);
    toggle = 1'b0;
    @(posedge clock);
    #1;

    // Orphan word outside a packet, then a good packet.
    base = log_d0.size();
    n = ferr_cnt;
    send(mk(2'd0, 1'b1, 1'b0, 32'hDEADBEEF));
    send(mk(2'd0, 1'b1, 1'b1, 32'h11223344));
    drain();
    chk("orphan_ferr_cnt", ferr_cnt - n, 1);
    chk("orphan_len", log_d0.size() - base, 4);
    chk("orphan_next_first", log_d0[base], 8'h11);
    chk("orphan_next_sof", log_sof[base], 1'b0);

    // SOF while a packet is open: error, new packet still output.
    base = log_d0.size();
    n = ferr_cnt;
    send(mk(2'd0, 1'b0, 1'b1, 32'h21222324));
    send(mk(2'd3, 1'b1, 1'b1, 32'h31323334));
    drain();
    chk("resof_ferr_cnt", ferr_cnt - n, 1);
    chk("resof_len", log_d0.size() - base, 7);
    chk("resof_sof", log_sof[base + 4], 1'b0);
    chk("resof_last", log_d0[base + 6], 8'h33);

    // Clear after two bytes of a 4-word packet.
    base = log_d0.size();
    send(mk(2'd0, 1'b0, 1'b1, 32'hA0A1A2A3));
    n = 0;
    while (log_d0.size() < base + 2 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("clear_wait", log_d0.size() - base, 2);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    chk("clear_src_rdy_n", src_rdy_n0, 1'b1);
    chk("clear_no_more", log_d0.size() - base, 2);
    @(posedge clock);
    #1;
    base = log_d0.size();
    send(mk(2'd0, 1'b1, 1'b1, 32'hB0B1B2B3));
    drain();
    chk("after_clear_len", log_d0.size() - base, 4);
    chk("after_clear_first", log_d0[base], 8'hB0);
    chk("after_clear_sof", log_sof[base], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo36_to_ll8.md
Name: fifo36_to_ll8

Overview:
Reader end of the 36-bit FIFO stream. Accepts 36-bit words (32 data bits plus framing flags) from a FIFO's src_rdy/dst_rdy interface and serializes each word into 8-bit LocalLink bytes for the GEMAC transmit path. It sits between the tx packet FIFO output and the MAC's 8-bit LL input. It sustains 1 byte/cycle with no bubbles between words or packets.

Parameters:
LE, 0, byte order within a word: 0 = bits 31:24 sent first; 1 = bits 7:0 sent first

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous clear; same effect as reset
datain  in  36  [31:0] data, [32] SOF, [33] EOF, [35:34] occ (valid bytes on the EOF word: 0 = 4, 1..3 = that count)
src_rdy_i  in  1  datain valid
dst_rdy_o  out  1  block accepts datain this cycle
ll_data  out  8  output byte
ll_sof_n  out  1  active-low start of frame
ll_eof_n  out  1  active-low end of frame
ll_src_rdy_n  out  1  active-low byte valid
ll_dst_rdy_n  in  1  active-low sink ready
framing_err  out  1  one-cycle pulse on a framing violation

Behaviour:
- Reset or clear: holding register empty, byte index = 0, state WAIT_SOF. Outputs: ll_src_rdy_n=1, ll_sof_n=1, ll_eof_n=1, ll_data=0, framing_err=0, dst_rdy_o=1.
- Input transfer occurs on a clock edge with src_rdy_i & dst_rdy_o. Output transfer occurs on an edge with ~ll_src_rdy_n & ~ll_dst_rdy_n.
- Holding register: one 36-bit word plus a valid bit and a 2-bit byte index.
  - dst_rdy_o = ~valid | (last_byte & ~ll_dst_rdy_n). dst_rdy_o is combinational from the sink ready, which allows back-to-back words.
  - last_byte = (index == 3) on non-EOF words. On EOF words, last_byte = (index == nbytes-1), where nbytes = (occ==0) ? 4 : occ.
- Latency: the first byte of an accepted word is presented the cycle after acceptance. Steady state is 1 byte/cycle.
- ll_src_rdy_n = ~valid. ll_data is the byte selected by index and LE.
  - ll_sof_n = 0 only on byte 0 of a word with SOF.
  - ll_eof_n = 0 only on the last_byte of a word with EOF.
- Outputs hold stable while ll_dst_rdy_n=1 (backpressure). Index advances only on an output transfer. On an output transfer at last_byte, index returns to 0.
- Framing FSM, updated on input acceptance:
  - WAIT_SOF, word with SOF: load the word. If EOF is also set, stay in WAIT_SOF; otherwise go to IN_PKT.
  - WAIT_SOF, word without SOF: consume and discard it (no LL output), pulse framing_err.
  - IN_PKT, word with EOF: load the word, go to WAIT_SOF.
  - IN_PKT, word with SOF: pulse framing_err and still load the word as a new packet start. The previous packet is left without EOF. Next state follows the word's EOF bit.
- A single-word packet with SOF, EOF and occ=1 produces one byte with both sof_n and eof_n low.
- occ is ignored on non-EOF words.
- Reset or clear mid-packet drops the held word immediately. No EOF is emitted.

Decomposition:
- Shared package: field positions (SOF_BIT=32, EOF_BIT=33, OCC_LSB=34), the occ-to-nbytes function, and FSM state encodings (WAIT_SOF, IN_PKT).
- No sub-module; a single flat module.

Test Plan:
- Packet of 3 words, 0x01020304 (SOF), 0x05060708, 0x090A0B0C (EOF, occ=0), sink always ready, LE=0 → bytes 01..0C on 12 consecutive cycles; sof_n low on byte 01 only, eof_n low on byte 0C only; dst_rdy_o never drops the stream rate.
- Same packet with EOF word occ=2 → 10 bytes, ending 09,0A; eof_n low on 0A.
- Single word 0xAABBCCDD with SOF|EOF, occ=1 → one byte AA with sof_n=0 and eof_n=0; LE=1 variant → DD.
- Sink toggles ll_dst_rdy_n every other cycle → byte sequence unchanged; ll_data, sof_n and eof_n are held while not ready; no byte is lost or duplicated.
- Word without SOF in WAIT_SOF → framing_err pulses for one cycle, no LL output, and the next SOF packet is output correctly.
- Assert clear after 2 bytes of a 4-word packet → ll_src_rdy_n=1 the next cycle; a following SOF packet starts cleanly at byte 0.
